decode_scoreboard: RTL and testbench
====================================

Name: decode_scoreboard

Overview:
- Decode-stage issue gate sitting directly upstream of the ID/EX control pipeline register.
- Tracks in-flight scalar and vector destination registers.
- Stalls decode on RAW/WAW hazards or when in-flight capacity is exhausted.
- Serialises halt and cache-flush instructions: drains the pipe, issues them alone, then waits or parks.
- Produces the `issue` strobe that qualifies the control bus entering the ID/EX register.

Parameters:
- NUM_SREGS, 32, number of scalar registers tracked
- NUM_VREGS, 32, number of vector registers tracked
- REG_AW, 5, register index width
- MAX_INFLIGHT, 8, maximum register-writing instructions issued but not yet written back

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in decode
- id_register_wr_en  in  1  instruction writes a scalar register
- id_vector_wr_en  in  1  instruction writes a vector register (never both with scalar)
- id_scalar_write_register  in  REG_AW  scalar destination
- id_vector_write_register  in  REG_AW  vector destination
- id_r_read1, id_r_read2  in  1 each  scalar source enables
- id_scalar_read_register1, id_scalar_read_register2  in  REG_AW each  scalar sources
- id_v_read1, id_v_read2  in  1 each  vector source enables
- id_vector_read_register1, id_vector_read_register2  in  REG_AW each  vector sources
- id_halt  in  1  decode holds halt
- id_flush  in  1  decode holds flushicache or data_cache_flush
- wb_scalar_en  in  1  scalar writeback this cycle
- wb_scalar_reg  in  REG_AW  scalar writeback index
- wb_vector_en  in  1  vector writeback this cycle
- wb_vector_reg  in  REG_AW  vector writeback index
- ex_redirect  in  1  taken branch/jump; kill decode instruction this cycle
- flush_done  in  1  cache flush complete pulse
- stall_id  out  1  hold fetch/decode
- issue  out  1  instruction leaves decode this cycle
- flush_req  out  1  level, cache flush in progress
- halted  out  1  core halted
- inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding writers
- wb_error  out  1  sticky: writeback to non-pending register or with inflight==0

Behaviour:
- Reset values:
  - All pending bits 0, inflight 0, state RUN.
  - stall_id 0, issue 0, flush_req 0, halted 0, wb_error 0.
- Effective pending:
  - pend_eff = pending & ~wb-decode; same-cycle writeback clears the hazard with no stall.
- Hazard (combinational):
  - Any enabled source whose pend_eff bit is set (RAW).
  - Or the enabled destination's pend_eff bit is set (WAW).
- Full: inflight == MAX_INFLIGHT and the instruction writes.
- Issue rules:
  - `issue` = id_valid & ~ex_redirect & ~stall_cond.
  - stall_id = id_valid & stall_cond & ~ex_redirect.
  - Latency zero: combinational from the inputs.
- On issue with a write:
  - Set the destination pending bit.
  - inflight += 1.
- On writeback:
  - Clear the pending bit.
  - inflight -= count of writeback enables (0..2).
  - If the register is issued and written back the same cycle, set wins.
  - Net inflight change = issue_write − wb count.
  - inflight saturates at 0 with wb_error set.
- FSM:
  - RUN:
    - Normal instructions are gated by hazard/full.
    - For id_halt or id_flush with inflight == 0 and no pending bits: issue; halt → HALTED, flush → FLUSH_WAIT.
    - Otherwise stall → DRAIN.
  - DRAIN:
    - stall_cond = 1 until inflight == 0 after this cycle's writebacks.
    - Then issue the serialising instruction and branch as in RUN.
    - ex_redirect → RUN with no issue.
  - FLUSH_WAIT:
    - flush_req = 1; stall all.
    - flush_done → RUN next cycle; flush_req drops with the state change.
    - ex_redirect is ignored.
  - HALTED:
    - halted = 1; stall all; ex_redirect ignored; exit only via rst_n.
- rst_n asserted mid-operation clears all state immediately, including an outstanding flush_req.
- Register 0 has no special treatment; it is tracked like the others.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- Defined:
  - Adds output stall_count [31:0], incremented each cycle stall_id = 1.
  - Saturates at 0xFFFF_FFFF; reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Issue write s3, next cycle read s3, no writeback → stall_id=1 until the wb_scalar_en/reg=3 cycle, in which issue=1 (same-cycle bypass); inflight 1→0.
- Issue 8 vector writers to v0..v7 with no writeback, then a ninth writer v8 → stall_id=1, inflight=8. One wb v0 → ninth issues that cycle; inflight stays 8.
- Two writers in flight, id_flush presented → DRAIN. After both writebacks, issue=1, flush_req=1 and stall until the flush_done pulse; RUN the following cycle.
- id_halt with inflight 0 → issue=1, halted=1 next cycle. Further id_valid stays stalled; ex_redirect has no effect; rst_n low clears halted.
- DRAIN in progress plus ex_redirect=1 → issue=0, state RUN, pending bits unchanged.
- wb_scalar_en on reg 9 with inflight=0 → inflight stays 0, wb_error=1 and sticky until reset.

Source files
------------

// File: rtl/decode_scoreboard.sv
// Decode-stage scoreboard: RAW/WAW/capacity stall, halt/flush serialisation.
// Optional SCOREBOARD_STATS_EN adds a saturating stall_count output.
module decode_scoreboard #(
    parameter int NUM_SREGS    = 32,
    parameter int NUM_VREGS    = 32,
    parameter int REG_AW       = 5,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 id_valid,
    input  logic                                 id_register_wr_en,
    input  logic                                 id_vector_wr_en,
    input  logic [REG_AW-1:0]                    id_scalar_write_register,
    input  logic [REG_AW-1:0]                    id_vector_write_register,
    input  logic                                 id_r_read1,
    input  logic                                 id_r_read2,
    input  logic [REG_AW-1:0]                    id_scalar_read_register1,
    input  logic [REG_AW-1:0]                    id_scalar_read_register2,
    input  logic                                 id_v_read1,
    input  logic                                 id_v_read2,
    input  logic [REG_AW-1:0]                    id_vector_read_register1,
    input  logic [REG_AW-1:0]                    id_vector_read_register2,
    input  logic                                 id_halt,
    input  logic                                 id_flush,
    input  logic                                 wb_scalar_en,
    input  logic [REG_AW-1:0]                    wb_scalar_reg,
    input  logic                                 wb_vector_en,
    input  logic [REG_AW-1:0]                    wb_vector_reg,
    input  logic                                 ex_redirect,
    input  logic                                 flush_done,
    output logic                                 stall_id,
    output logic                                 issue,
    output logic                                 flush_req,
    output logic                                 halted,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
    output logic                                 wb_error
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                          stall_count
`endif
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] MAXI = IW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_FLUSH_WAIT,
        S_HALTED
    } state_t;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [NUM_SREGS-1:0]   r_spend;
    logic [NUM_VREGS-1:0]   r_vpend;
    logic [NUM_SREGS-1:0]   w_swb_mask;
    logic [NUM_VREGS-1:0]   w_vwb_mask;
    logic [NUM_SREGS-1:0]   w_siss_mask;
    logic [NUM_VREGS-1:0]   w_viss_mask;
    logic [NUM_SREGS-1:0]   w_spend_eff;
    logic [NUM_VREGS-1:0]   w_vpend_eff;
    logic [IW-1:0]          r_inflight;
    logic [IW-1:0]          w_wbc;
    logic [IW-1:0]          w_infl_wb;
    logic                   r_wb_error;
    logic                   w_ser;
    logic                   w_wr;
    logic                   w_haz;
    logic                   w_full;
    logic                   w_idle;
    logic                   w_stall_cond;
    logic                   w_blk;
    logic                   w_iss_wr;
    logic                   w_wb_bad;

    // Decode writeback and issue destinations into one-hot masks
    always_comb begin
        w_swb_mask  = '0;
        w_vwb_mask  = '0;
        w_siss_mask = '0;
        w_viss_mask = '0;
        if (wb_scalar_en) w_swb_mask[wb_scalar_reg] = 1'b1;
        if (wb_vector_en) w_vwb_mask[wb_vector_reg] = 1'b1;
        if (issue && id_register_wr_en)
            w_siss_mask[id_scalar_write_register] = 1'b1;
        if (issue && id_vector_wr_en)
            w_viss_mask[id_vector_write_register] = 1'b1;
    end

    assign w_spend_eff = r_spend & ~w_swb_mask;
    assign w_vpend_eff = r_vpend & ~w_vwb_mask;

    assign w_ser = id_halt | id_flush;
    assign w_wr  = id_register_wr_en | id_vector_wr_en;

    assign w_haz =
        (id_r_read1 & w_spend_eff[id_scalar_read_register1]) |
        (id_r_read2 & w_spend_eff[id_scalar_read_register2]) |
        (id_v_read1 & w_vpend_eff[id_vector_read_register1]) |
        (id_v_read2 & w_vpend_eff[id_vector_read_register2]) |
        (id_register_wr_en & w_spend_eff[id_scalar_write_register]) |
        (id_vector_wr_en & w_vpend_eff[id_vector_write_register]);

    assign w_wbc = {{(IW-1){1'b0}}, wb_scalar_en} +
                   {{(IW-1){1'b0}}, wb_vector_en};
    assign w_infl_wb = (r_inflight >= w_wbc) ? (r_inflight - w_wbc) : '0;
    assign w_full = w_wr & (w_infl_wb >= MAXI);
    assign w_idle = (r_inflight == '0) && !(|r_spend) && !(|r_vpend);

    // Writeback to a register that is not pending, or beyond inflight
    assign w_wb_bad = (wb_scalar_en & ~r_spend[wb_scalar_reg]) |
                      (wb_vector_en & ~r_vpend[wb_vector_reg]) |
                      (w_wbc > r_inflight);

    // Next-state and stall condition for the serialisation FSM
    always_comb begin
        w_state_n    = r_state;
        w_stall_cond = 1'b0;
        w_blk        = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_ser) begin
                    w_stall_cond = ~w_idle;
                    if (id_valid && !ex_redirect)
                        w_state_n = w_idle ?
                            (id_halt ? S_HALTED : S_FLUSH_WAIT) : S_DRAIN;
                end else begin
                    w_stall_cond = w_haz | w_full;
                end
            end
            S_DRAIN: begin
                w_stall_cond = ~(w_ser && (w_infl_wb == '0));
                if (ex_redirect)
                    w_state_n = S_RUN;
                else if (id_valid && !w_stall_cond)
                    w_state_n = id_halt ? S_HALTED : S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
                w_blk = 1'b1;
                if (flush_done) w_state_n = S_RUN;
            end
            S_HALTED: begin
                w_blk = 1'b1;
            end
            default: w_state_n = S_RUN;
        endcase
    end

    assign issue    = ~w_blk & id_valid & ~ex_redirect & ~w_stall_cond;
    assign stall_id = w_blk ? id_valid
                            : (id_valid & w_stall_cond & ~ex_redirect);
    assign w_iss_wr = issue & w_wr;

    assign flush_req = (r_state == S_FLUSH_WAIT);
    assign halted    = (r_state == S_HALTED);
    assign inflight  = r_inflight;
    assign wb_error  = r_wb_error;

    // State, pending bits, inflight count and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_spend    <= '0;
            r_vpend    <= '0;
            r_inflight <= '0;
            r_wb_error <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_spend    <= w_spend_eff | w_siss_mask;
            r_vpend    <= w_vpend_eff | w_viss_mask;
            r_inflight <= w_infl_wb + {{(IW-1){1'b0}}, w_iss_wr};
            if (w_wb_bad) r_wb_error <= 1'b1;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_count;

    // Saturating count of stalled decode cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_count <= '0;
        else if (stall_id && (r_stall_count != 32'hFFFF_FFFF))
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: table vectors plus
// hand sequences for drain, flush, halt, redirect and reset.
module tb_decode_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_register_wr_en, id_vector_wr_en;
    logic [4:0] id_scalar_write_register, id_vector_write_register;
    logic       id_r_read1, id_r_read2, id_v_read1, id_v_read2;
    logic [4:0] id_scalar_read_register1, id_scalar_read_register2;
    logic [4:0] id_vector_read_register1, id_vector_read_register2;
    logic       id_halt, id_flush;
    logic       wb_scalar_en, wb_vector_en;
    logic [4:0] wb_scalar_reg, wb_vector_reg;
    logic       ex_redirect, flush_done;
    logic       stall_id, issue, flush_req, halted, wb_error;
    logic [3:0] inflight;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_count;
`endif

    int ntot = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    decode_scoreboard dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .id_valid                 (id_valid),
        .id_register_wr_en        (id_register_wr_en),
        .id_vector_wr_en          (id_vector_wr_en),
        .id_scalar_write_register (id_scalar_write_register),
        .id_vector_write_register (id_vector_write_register),
        .id_r_read1               (id_r_read1),
        .id_r_read2               (id_r_read2),
        .id_scalar_read_register1 (id_scalar_read_register1),
        .id_scalar_read_register2 (id_scalar_read_register2),
        .id_v_read1               (id_v_read1),
        .id_v_read2               (id_v_read2),
        .id_vector_read_register1 (id_vector_read_register1),
        .id_vector_read_register2 (id_vector_read_register2),
        .id_halt                  (id_halt),
        .id_flush                 (id_flush),
        .wb_scalar_en             (wb_scalar_en),
        .wb_scalar_reg            (wb_scalar_reg),
        .wb_vector_en             (wb_vector_en),
        .wb_vector_reg            (wb_vector_reg),
        .ex_redirect              (ex_redirect),
        .flush_done               (flush_done),
        .stall_id                 (stall_id),
        .issue                    (issue),
        .flush_req                (flush_req),
        .halted                   (halted),
        .inflight                 (inflight),
        .wb_error                 (wb_error)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_count              (stall_count)
`endif
    );

    typedef struct {
        int v;
        int sw;
        int vw;
        int dst;
        int rs;
        int vs;
        int src;
        int ws;
        int wsr;
        int wv;
        int wvr;
        int ei;
        int es;
        int einf;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        id_valid = 0; id_register_wr_en = 0; id_vector_wr_en = 0;
        id_scalar_write_register = 0; id_vector_write_register = 0;
        id_r_read1 = 0; id_r_read2 = 0; id_v_read1 = 0; id_v_read2 = 0;
        id_scalar_read_register1 = 0; id_scalar_read_register2 = 0;
        id_vector_read_register1 = 0; id_vector_read_register2 = 0;
        id_halt = 0; id_flush = 0;
        wb_scalar_en = 0; wb_scalar_reg = 0;
        wb_vector_en = 0; wb_vector_reg = 0;
        ex_redirect = 0; flush_done = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input vec_t t);
        clr();
        id_valid                 = t.v[0];
        id_register_wr_en        = t.sw[0];
        id_vector_wr_en          = t.vw[0];
        id_scalar_write_register = t.dst[4:0];
        id_vector_write_register = t.dst[4:0];
        id_r_read1               = t.rs[0];
        id_v_read1               = t.vs[0];
        id_scalar_read_register1 = t.src[4:0];
        id_vector_read_register1 = t.src[4:0];
        wb_scalar_en             = t.ws[0];
        wb_scalar_reg            = t.wsr[4:0];
        wb_vector_en             = t.wv[0];
        wb_vector_reg            = t.wvr[4:0];
    endtask

    initial begin
        // v sw vw dst rs vs src ws wsr wv wvr ei es einf
        tbl[0]  = '{1,1,0,3, 0,0,0, 0,0, 0,0, 1,0,0};
        tbl[1]  = '{1,0,0,0, 1,0,3, 0,0, 0,0, 0,1,1};
        tbl[2]  = '{1,0,0,0, 1,0,3, 0,0, 0,0, 0,1,1};
        tbl[3]  = '{1,0,0,0, 1,0,3, 1,3, 0,0, 1,0,1};
        tbl[4]  = '{0,0,0,0, 0,0,0, 0,0, 0,0, 0,0,0};
        tbl[5]  = '{1,1,0,4, 0,0,0, 0,0, 0,0, 1,0,0};
        tbl[6]  = '{1,1,0,4, 0,0,0, 0,0, 0,0, 0,1,1};
        tbl[7]  = '{1,1,0,4, 0,0,0, 1,4, 0,0, 1,0,1};
        tbl[8]  = '{1,0,0,0, 1,0,4, 0,0, 0,0, 0,1,1};
        tbl[9]  = '{0,0,0,0, 0,0,0, 1,4, 0,0, 0,0,1};
        tbl[10] = '{0,0,0,0, 0,0,0, 0,0, 0,0, 0,0,0};
        tbl[11] = '{1,1,0,0, 0,0,0, 0,0, 0,0, 1,0,0};
        tbl[12] = '{1,0,0,0, 1,0,0, 0,0, 0,0, 0,1,1};
        tbl[13] = '{0,0,0,0, 0,0,0, 1,0, 0,0, 0,0,1};
        for (int k = 0; k < 8; k++)
            tbl[14+k] = '{1,0,1,k, 0,0,0, 0,0, 0,0, 1,0,k};
        tbl[22] = '{1,0,1,8, 0,0,0, 0,0, 0,0, 0,1,8};
        tbl[23] = '{1,0,1,8, 0,0,0, 0,0, 1,0, 1,0,8};
        tbl[24] = '{0,0,0,0, 0,0,0, 0,0, 0,0, 0,0,8};
        tbl[25] = '{1,0,0,0, 0,1,1, 0,0, 0,0, 0,1,8};
        tbl[26] = '{1,0,0,0, 0,1,0, 0,0, 0,0, 1,0,8};

        clr();
        rst_n = 1'b0;
        #12;
        chk("rst_stall", int'(stall_id), 0);
        chk("rst_issue", int'(issue), 0);
        chk("rst_flush_req", int'(flush_req), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_inflight", int'(inflight), 0);
        chk("rst_wb_error", int'(wb_error), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            set_in(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d_issue", i), int'(issue), tbl[i].ei);
            chk($sformatf("row%0d_stall", i), int'(stall_id), tbl[i].es);
            chk($sformatf("row%0d_infl", i), int'(inflight), tbl[i].einf);
            step();
        end

        // drain v1..v8 back to empty
        for (int k = 1; k <= 8; k++) begin
            clr();
            wb_vector_en = 1'b1;
            wb_vector_reg = 5'(k);
            @(negedge clk);
            chk($sformatf("drain_v%0d_infl", k), int'(inflight), 9 - k);
            step();
        end
        clr();
        @(negedge clk);
        chk("empty_infl", int'(inflight), 0);
        chk("no_err_yet", int'(wb_error), 0);
        step();

        // flush with two writers in flight
        clr(); id_valid = 1; id_register_wr_en = 1;
        id_scalar_write_register = 1;
        @(negedge clk); chk("fl_w1_issue", int'(issue), 1); step();
        id_scalar_write_register = 2;
        @(negedge clk); chk("fl_w2_issue", int'(issue), 1); step();
        clr(); id_valid = 1; id_flush = 1;
        @(negedge clk);
        chk("fl_run_stall", int'(stall_id), 1);
        chk("fl_run_issue", int'(issue), 0);
        step();
        wb_scalar_en = 1; wb_scalar_reg = 1;
        @(negedge clk);
        chk("fl_drain1_stall", int'(stall_id), 1);
        chk("fl_drain1_infl", int'(inflight), 2);
        step();
        wb_scalar_reg = 2;
        @(negedge clk);
        chk("fl_drain2_issue", int'(issue), 1);
        chk("fl_drain2_stall", int'(stall_id), 0);
        step();
        clr(); id_valid = 1; ex_redirect = 1;
        @(negedge clk);
        chk("fw_flush_req", int'(flush_req), 1);
        chk("fw_stall", int'(stall_id), 1);
        chk("fw_issue", int'(issue), 0);
        chk("fw_infl", int'(inflight), 0);
        step();
        ex_redirect = 0; flush_done = 1;
        @(negedge clk);
        chk("fw_done_req", int'(flush_req), 1);
        chk("fw_done_stall", int'(stall_id), 1);
        step();
        flush_done = 0;
        @(negedge clk);
        chk("fw_after_req", int'(flush_req), 0);
        chk("fw_after_issue", int'(issue), 1);
        step();

        // redirect while draining for a halt
        clr(); id_valid = 1; id_register_wr_en = 1;
        id_scalar_write_register = 5;
        @(negedge clk); chk("dr_w5_issue", int'(issue), 1); step();
        clr(); id_valid = 1; id_halt = 1;
        @(negedge clk); chk("dr_halt_stall", int'(stall_id), 1); step();
        ex_redirect = 1;
        @(negedge clk);
        chk("dr_redir_issue", int'(issue), 0);
        chk("dr_redir_stall", int'(stall_id), 0);
        step();
        clr(); id_valid = 1; id_r_read1 = 1; id_scalar_read_register1 = 6;
        @(negedge clk); chk("dr_run_issue", int'(issue), 1); step();
        id_scalar_read_register1 = 5;
        @(negedge clk); chk("dr_pend_kept", int'(stall_id), 1); step();
        clr(); wb_scalar_en = 1; wb_scalar_reg = 5;
        @(negedge clk); chk("dr_infl1", int'(inflight), 1); step();
        clr();
        @(negedge clk); chk("dr_infl0", int'(inflight), 0);
        chk("dr_no_err", int'(wb_error), 0);
        step();

        // writeback with nothing in flight
        wb_scalar_en = 1; wb_scalar_reg = 9;
        @(negedge clk); chk("err_pre", int'(wb_error), 0); step();
        clr();
        @(negedge clk);
        chk("err_set", int'(wb_error), 1);
        chk("err_infl", int'(inflight), 0);
        step(); step(); step();
        @(negedge clk); chk("err_sticky", int'(wb_error), 1);
        step();

        // reset during a flush wait
        id_valid = 1; id_flush = 1;
        @(negedge clk); chk("rf_issue", int'(issue), 1); step();
        clr();
        @(negedge clk); chk("rf_req", int'(flush_req), 1);
        rst_n = 1'b0;
        #1;
        chk("rf_req_clr", int'(flush_req), 0);
        chk("rf_err_clr", int'(wb_error), 0);
        step();
        rst_n = 1'b1;

        // halt and park
        id_valid = 1; id_halt = 1;
        @(negedge clk); chk("h_issue", int'(issue), 1); step();
        clr(); id_valid = 1;
        @(negedge clk);
        chk("h_halted", int'(halted), 1);
        chk("h_stall", int'(stall_id), 1);
        chk("h_issue0", int'(issue), 0);
        step();
        ex_redirect = 1;
        @(negedge clk);
        chk("h_redir_stall", int'(stall_id), 1);
        chk("h_redir_halted", int'(halted), 1);
        chk("h_redir_issue", int'(issue), 0);
        step();
        clr();
        rst_n = 1'b0;
        #1;
        chk("h_rst_halted", int'(halted), 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("h_rst_stall", int'(stall_id), 0);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
